pc_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the 9-bit, 8-opcode core.
- Owns the program counter and walks each instruction through FETCH → EXEC (→ MEM_WAIT for loads).
- Gates the Control decoder's RegWrite/MemWrite into single-cycle strobes.
- Runs the start/done handshake with the testbench. Sits between the instruction ROM, the Control decoder, the register file and the data memory.

---
 rtl/pc_seq_pkg.sv | 24 ++
 rtl/pc_sequencer_mem_wait_ctr.sv | 30 +++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the multi-cycle sequencer of the 9-bit, 8-opcode core:
// sequencer states, opcode encodings and the default program-counter width.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM_WAIT,
        DONE
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ROR   = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_MOVE  = 3'b101;
    localparam logic [2:0] OP_BNE   = 3'b110;
    localparam logic [2:0] OP_SET   = 3'b111;

    localparam int DEFAULT_PC_W = 10;

endpackage

// File: rtl/pc_sequencer_mem_wait_ctr.sv
// Load-latency counter: cleared when a load issues, counts the MEM_WAIT cycles
// and flags the last one (count == MEM_LAT-1).
module mem_wait_ctr #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [W-1:0] LAST = W'(MEM_LAT - 1);

    logic [W-1:0] count;

    // NOTE: sequential state is written with <= so every register samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: owns the PC, walks FETCH -> EXEC (-> MEM_WAIT for
// loads), gates decoder write enables into strobes and runs start/done.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W     = DEFAULT_PC_W,
    parameter int PROG_LEN = 1024,
    parameter int MEM_LAT  = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dec_regwrite,
    input  logic             dec_memwrite,
    input  logic             dec_memtoreg,
    input  logic             dec_branch,
    input  logic             dec_halt,
    input  logic             alu_zero,
    input  logic [PC_W-1:0]  branch_target,
    output logic [PC_W-1:0]  pc,
    output logic             ir_load,
    output logic             reg_we,
    output logic             mem_we,
    output logic             mem_re,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [PC_W-1:0]  LAST_PC = PC_W'(PROG_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    logic   wait_tc;
    logic   exec_live;
    logic   load_issue;
    logic   taken;
    logic   at_end;

    assign exec_live  = (state == EXEC) && !dec_halt;
    assign load_issue = exec_live && dec_memtoreg;
    assign taken      = dec_branch && !alu_zero;
    assign at_end     = (pc == LAST_PC);

    mem_wait_ctr #(.MEM_LAT(MEM_LAT)) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr   (load_issue),
        .en    (state == MEM_WAIT),
        .tc    (wait_tc)
    );

    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        ir_load = 1'b0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            FETCH: begin
                ir_load = 1'b1;
                busy    = 1'b1;
            end
            EXEC: begin
                busy   = 1'b1;
                mem_re = load_issue;
                // Store wins if the decoder ever raises both write enables.
                mem_we = exec_live && !dec_memtoreg && dec_memwrite;
                reg_we = exec_live && !dec_memtoreg && dec_regwrite && !dec_memwrite;
            end
            MEM_WAIT: begin
                busy   = 1'b1;
                mem_re = 1'b1;
                reg_we = wait_tc;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            cycle_count <= '0;
        end else begin
            if (busy && cycle_count != CNT_MAX) begin
                cycle_count <= cycle_count + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= FETCH;
                        pc          <= '0;
                        cycle_count <= '0;
                    end
                end
                FETCH: state <= EXEC;
                EXEC: begin
                    if (dec_halt) begin
                        state <= DONE;
                    end else if (dec_memtoreg) begin
                        state <= MEM_WAIT;
                    end else if (taken) begin
                        pc    <= branch_target;
                        state <= FETCH;
                    end else if (at_end) begin
                        state <= DONE;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= FETCH;
                    end
                end
                MEM_WAIT: begin
                    if (wait_tc) begin
                        if (at_end) begin
                            state <= DONE;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    // A new run must pass through IDLE, so wait for start to drop.
                    if (!start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench: a program table drives the decoder inputs and
// an instruction-level model predicts every cycle of each run.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int PC_W     = 6;
    localparam int PROG_LEN = 32;
    localparam int MEM_LAT  = 2;
    localparam int CNT_W    = 5;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [2:0]      op;
        logic            halt;
        logic            zero;
        logic [PC_W-1:0] target;
    } word_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             dec_regwrite, dec_memwrite, dec_memtoreg, dec_branch, dec_halt;
    logic             alu_zero;
    logic [PC_W-1:0]  branch_target;
    logic [PC_W-1:0]  pc;
    logic             ir_load, reg_we, mem_we, mem_re, busy, done;
    logic [CNT_W-1:0] cycle_count;

    word_t prog [2**PC_W];
    word_t cur;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    int          final_pc;
    int          total;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W(PC_W), .PROG_LEN(PROG_LEN), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .dec_regwrite  (dec_regwrite),
        .dec_memwrite  (dec_memwrite),
        .dec_memtoreg  (dec_memtoreg),
        .dec_branch    (dec_branch),
        .dec_halt      (dec_halt),
        .alu_zero      (alu_zero),
        .branch_target (branch_target),
        .pc            (pc),
        .ir_load       (ir_load),
        .reg_we        (reg_we),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .busy          (busy),
        .done          (done),
        .cycle_count   (cycle_count)
    );

    // Instruction ROM plus Control decoder, addressed by the DUT's pc.
    assign cur           = prog[pc];
    assign dec_halt      = cur.halt;
    assign dec_memtoreg  = (cur.op == OP_LOAD);
    assign dec_memwrite  = (cur.op == OP_STORE);
    assign dec_branch    = (cur.op == OP_BNE);
    assign dec_regwrite  = is_regwrite(cur.op);
    assign alu_zero      = cur.zero;
    assign branch_target = cur.target;

    function automatic logic is_regwrite(input logic [2:0] op);
        return op inside {OP_ADD, OP_ROR, OP_NAND, OP_LOAD, OP_MOVE, OP_SET};
    endfunction

    function automatic logic [CNT_W-1:0] sat(input int n);
        return (n > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(n);
    endfunction

    function automatic logic [31:0] pack(input int p, input logic ir, input logic rw,
                                         input logic mw, input logic mr, input logic bz,
                                         input logic dn, input int cc);
        return 32'({PC_W'(p), ir, rw, mw, mr, bz, dn, sat(cc)});
    endfunction

    function automatic logic [31:0] observed();
        return 32'({pc, ir_load, reg_we, mem_we, mem_re, busy, done, cycle_count});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 2**PC_W; i++) begin
            prog[i] = '{op: OP_ADD, halt: 1'b0, zero: 1'b1, target: '0};
        end
    endtask

    task automatic rand_prog();
        for (int i = 0; i < 2**PC_W; i++) begin
            prog[i].op     = 3'($urandom_range(0, 7));
            prog[i].halt   = ($urandom_range(0, 24) == 0);
            prog[i].zero   = 1'($urandom_range(0, 1));
            // Forward-only branches keep every run finite.
            prog[i].target = (i < PROG_LEN - 1) ? PC_W'($urandom_range(i + 1, PROG_LEN - 1)) : '0;
            if (i >= PROG_LEN - 1 && prog[i].op == OP_BNE) prog[i].op = OP_ADD;
        end
    endtask

    // Instruction-level model: expands the program into expected per-cycle outputs.
    task automatic build_trace();
        int    p;
        int    j;
        bit    fin;
        word_t w;
        p = 0;
        j = 0;
        fin = 0;
        exp_q.delete();
        while (!fin) begin
            w = prog[p];
            exp_q.push_back(pack(p, 1, 0, 0, 0, 1, 0, j)); j++;
            if (w.halt) begin
                exp_q.push_back(pack(p, 0, 0, 0, 0, 1, 0, j)); j++;
                fin = 1;
            end else if (w.op == OP_LOAD) begin
                exp_q.push_back(pack(p, 0, 0, 0, 1, 1, 0, j)); j++;
                for (int k = 0; k < MEM_LAT; k++) begin
                    exp_q.push_back(pack(p, 0, (k == MEM_LAT - 1), 0, 1, 1, 0, j)); j++;
                end
                if (p == PROG_LEN - 1) fin = 1; else p++;
            end else begin
                exp_q.push_back(pack(p, 0, is_regwrite(w.op), (w.op == OP_STORE), 0, 1, 0, j)); j++;
                if (w.op == OP_BNE && !w.zero) p = int'(w.target);
                else if (p == PROG_LEN - 1)    fin = 1;
                else                           p++;
            end
        end
        final_pc = p;
        total    = j;
    endtask

    // Runs the current trace; abort_at >= 0 asserts reset in that busy cycle.
    task automatic run_program(input string name, input int abort_at);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check({name, "_abort"}, observed(), pack(0, 0, 0, 0, 0, 0, 0, 0));
                reset = 1'b0;
                start = 1'b0;
                @(negedge clk);
                check({name, "_abort_idle"}, observed(), pack(0, 0, 0, 0, 0, 0, 0, 0));
                return;
            end
            check($sformatf("%s_cyc%0d", name, i), observed(), exp_q[i]);
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check({name, "_done"}, observed(), pack(final_pc, 0, 0, 0, 0, 0, 1, total));
        start = 1'b1;
        repeat (2) @(negedge clk);
        check({name, "_done_hold"}, observed(), pack(final_pc, 0, 0, 0, 0, 0, 1, total));
        start = 1'b0;
        @(negedge clk);
        check({name, "_idle"}, observed(), pack(final_pc, 0, 0, 0, 0, 0, 0, total));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_prog();
        repeat (2) @(negedge clk);
        check("reset", observed(), pack(0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        // ADD, ADD, halt
        prog[2].halt = 1'b1;
        build_trace();
        run_program("add_add_halt", -1);

        // Load followed by halt
        clear_prog();
        prog[0].op = OP_LOAD;
        prog[1].halt = 1'b1;
        build_trace();
        run_program("load", -1);

        // BNE at pc=5: taken to 20, then not taken into a STORE
        clear_prog();
        prog[5]  = '{op: OP_BNE, halt: 1'b0, zero: 1'b0, target: PC_W'(20)};
        prog[6]  = '{op: OP_STORE, halt: 1'b0, zero: 1'b1, target: '0};
        prog[7].halt  = 1'b1;
        prog[20].halt = 1'b1;
        build_trace();
        run_program("bne_taken", -1);
        prog[5].zero = 1'b1;
        build_trace();
        run_program("bne_fall", -1);

        // No halt: end of program and cycle-count saturation
        clear_prog();
        build_trace();
        run_program("run_off_end", -1);

        // Reset during MEM_WAIT (trace index 2 is the first MEM_WAIT cycle)
        clear_prog();
        prog[0].op = OP_LOAD;
        prog[1].halt = 1'b1;
        build_trace();
        run_program("abort_memwait", 2);

        for (int r = 0; r < 30; r++) begin
            int ab;
            rand_prog();
            build_trace();
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
            run_program($sformatf("rand%0d", r), ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
